// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Multi-cycle shift-add multiplier with its own sequencing FSM. Owns the HI/LO
// result registers and stalls the pipeline while a multiply is in progress.
// Signed operands are converted to magnitudes, multiplied unsigned, and the
// product is negated on completion if the operand signs differ.
//
// Ports:
//   clk_i     system clock, rising edge
//   rst_i     asynchronous active-low reset
//   start_i   level request: current instruction is a multiply
//   signed_i  1 = signed (mult), 0 = unsigned (multu); sampled with start_i
//   src1_i    multiplicand (rs)
//   src2_i    multiplier (rt)
//   busy_o    high while the FSM is in RUN
//   done_o    one-cycle pulse; HI/LO valid from this cycle
//   stall_o   combinational hold request for PC / writeback
//   hi_o      upper product word (HI register)
//   lo_o      lower product word (LO register)
//
// Optional build macro:
//   MULT_EARLY_EXIT_EN  finish as soon as the remaining multiplier bits are
//                       all zero instead of always running WIDTH cycles.
// -----------------------------------------------------------------------------
module mult_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH-1);

   logic [1:0]         state_q,  state_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;
   logic [2*WIDTH-1:0] mcand_q,  mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               neg_q,    neg_d;
   logic [WIDTH-1:0]   hi_q,     hi_d;
   logic [WIDTH-1:0]   lo_q,     lo_d;

   logic [2*WIDTH-1:0] acc_sum;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH-1:0]   mplier_shr;
   logic               last_cycle;

   // Magnitudes for the signed case. Negating the most-negative value wraps
   // back to itself, which read as unsigned is exactly 2^(WIDTH-1).
   assign mag1 = (signed_i && src1_i[WIDTH-1]) ? (~src1_i + ONE_W) : src1_i;
   assign mag2 = (signed_i && src2_i[WIDTH-1]) ? (~src2_i + ONE_W) : src2_i;

   // Accumulator value after this cycle's conditional add, and the signed
   // result that is committed to HI/LO on the final RUN edge.
   assign acc_sum    = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign prod       = neg_q ? (~acc_sum + ONE_2W) : acc_sum;
   assign mplier_shr = mplier_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
   // No multiplier bits left means no further additions can change acc.
   assign last_cycle = (cnt_q == CNT_LAST) || (mplier_shr == '0);
`else
   assign last_cycle = (cnt_q == CNT_LAST);
`endif

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d  = ST_RUN;
               acc_d    = '0;
               cnt_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, mag1};
               mplier_d = mag2;
               neg_d    = signed_i & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            end
         end
         ST_RUN: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_shr;
            cnt_d    = cnt_q + CNT_ONE;
            if (last_cycle) begin
               state_d = ST_DONE;
               hi_d    = prod[2*WIDTH-1:WIDTH];
               lo_d    = prod[WIDTH-1:0];
            end
         end
         ST_DONE: begin
            // start_i deliberately ignored so the stalled instruction retires.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy_o  = (state_q == ST_RUN);
   assign done_o  = (state_q == ST_DONE);
   // Qualified by reset so a start request held through reset does not stall.
   assign stall_o = rst_i & (((state_q == ST_IDLE) & start_i) | (state_q == ST_RUN));
   assign hi_o    = hi_q;
   assign lo_o    = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Self-checking bench for mult_seq_ctrl: a table of directed vectors, a few
// random vectors checked against a 64-bit reference multiply, plus hand-written
// sequences for start held through RUN, back-to-back relaunch and reset
// during RUN. Expected results go into a scoreboard queue at launch and are
// popped when done_o is seen.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sgn;
   logic [W-1:0] a, b;
   logic         busy, done, stall;
   logic [W-1:0] hi, lo;

   always #5 clk = ~clk;

   mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i    (clk),
      .rst_i    (rst_n),
      .start_i  (start),
      .signed_i (sgn),
      .src1_i   (a),
      .src2_i   (b),
      .busy_o   (busy),
      .done_o   (done),
      .stall_o  (stall),
      .hi_o     (hi),
      .lo_o     (lo)
   );

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } res_t;

   typedef struct packed {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         s;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } vec_t;

   res_t sb_q[$];
   res_t last_res;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference product: sign- or zero-extend to 64 bits, low 64 bits of product.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      logic [63:0] ex, ey, p;
      ex = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
      ey = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
      p  = ex * ey;
      return {p[63:32], p[31:0]};
   endfunction

   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                         input res_t exp, input string name);
      @(negedge clk);
      start = 1'b1;
      a     = ta;
      b     = tb_v;
      sgn   = ts;
      sb_q.push_back(exp);
      #1;
      check({name, "_stall_c0"}, 64'(stall), 64'd1);
   endtask

   // Waits for done_o. With hold=1 start stays high and operands change to 7/7
   // at cycle 5; returns positioned in the IDLE cycle after DONE.
   task automatic finish(input string name, input bit hold);
      int   n;
      bit   got;
      res_t r;
      n   = 0;
      got = 1'b0;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (!hold) start = 1'b0;
         else if (n == 5) begin
            a = 32'h7;
            b = 32'h7;
         end
         if (done) got = 1'b1;
         else if (busy !== 1'b1 || stall !== 1'b1) begin
            check({name, "_busy_run"}, 64'(busy), 64'd1);
            check({name, "_stall_run"}, 64'(stall), 64'd1);
         end
      end
      r = sb_q.pop_front();
      if (!got) begin
         total++;
         bad++;
         $display("FAIL %s_timeout actual=no_done required=done_within_200", name);
      end else begin
         check({name, "_hi"}, 64'(hi), 64'(r.hi));
         check({name, "_lo"}, 64'(lo), 64'(r.lo));
         check({name, "_stall_done"}, 64'(stall), 64'd0);
         check({name, "_busy_done"}, 64'(busy), 64'd0);
`ifndef MULT_EARLY_EXIT_EN
         check({name, "_latency"}, 64'(n), 64'(W + 1));
`endif
         last_res = r;
         $display("mult %s: hi=%h lo=%h cycles=%0d", name, hi, lo, n);
      end
      @(posedge clk);
      #1;
      check({name, "_done_pulse"}, 64'(done), 64'd0);
      check({name, "_busy_idle"}, 64'(busy), 64'd0);
      check({name, "_stall_idle"}, 64'(stall), hold ? 64'd1 : 64'd0);
      check({name, "_hold_hi"}, 64'(hi), 64'(r.hi));
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{a:32'h3,        b:32'h5,        s:1'b0, hi:32'h0,        lo:32'hF};
      vecs[1] = '{a:32'hFFFFFFFE, b:32'h3,        s:1'b1, hi:32'hFFFFFFFF, lo:32'hFFFFFFFA};
      vecs[2] = '{a:32'hFFFFFFFE, b:32'h3,        s:1'b0, hi:32'h2,        lo:32'hFFFFFFFA};
      vecs[3] = '{a:32'h80000000, b:32'h80000000, s:1'b1, hi:32'h40000000, lo:32'h0};
      vecs[4] = '{a:32'hFFFFFFFF, b:32'hFFFFFFFF, s:1'b0, hi:32'hFFFFFFFE, lo:32'h1};
      vecs[5] = '{a:32'h1234,     b:32'h1,        s:1'b0, hi:32'h0,        lo:32'h1234};
      vecs[6] = '{a:32'h1,        b:32'h80000000, s:1'b0, hi:32'h0,        lo:32'h80000000};
      vecs[7] = '{a:32'h80000000, b:32'h1,        s:1'b1, hi:32'hFFFFFFFF, lo:32'h80000000};
      vecs[8] = '{a:32'h0,        b:32'hFFFFFFFF, s:1'b1, hi:32'h0,        lo:32'h0};
      vecs[9] = '{a:32'hFFFFFFFF, b:32'hFFFFFFFF, s:1'b1, hi:32'h0,        lo:32'h1};

      // Reset state, with start held high to show stall is gated by reset.
      rst_n = 1'b0;
      start = 1'b1;
      sgn   = 1'b0;
      a     = '0;
      b     = '0;
      #2;
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_stall", 64'(stall), 64'd0);
      repeat (2) @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].s, '{hi:vecs[i].hi, lo:vecs[i].lo}, $sformatf("vec%0d", i));
         finish($sformatf("vec%0d", i), 1'b0);
      end

      // Random vectors against the reference model.
      for (int i = 0; i < 6; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         launch(ra, rb, rs, model(ra, rb, rs), $sformatf("rnd%0d", i));
         finish($sformatf("rnd%0d", i), 1'b0);
      end

      // start held through RUN with operands changed mid-run, then relaunch
      // from the IDLE cycle after DONE using the new operands.
      launch(32'h3, 32'h5, 1'b0, '{hi:32'h0, lo:32'hF}, "hold");
      finish("hold", 1'b1);
      sb_q.push_back('{hi:32'h0, lo:32'd49});
      finish("relaunch", 1'b0);

      // Reset during RUN cycle 10: abort, clear HI/LO, then a normal multiply.
      launch(32'h1234, 32'h5678, 1'b0, model(32'h1234, 32'h5678, 1'b0), "abort");
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_pre", 64'(busy), 64'd1);
      check("abort_hi_unchanged", 64'(hi), 64'(last_res.hi));
      check("abort_lo_unchanged", 64'(lo), 64'(last_res.lo));
      start = 1'b1;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_stall", 64'(stall), 64'd0);
      check("abort_hi", 64'(hi), 64'd0);
      check("abort_lo", 64'(lo), 64'd0);
      $display("mult abort: reset applied mid-run, hi=%h lo=%h", hi, lo);
      sb_q.delete();
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      launch(32'd6, 32'd7, 1'b0, '{hi:32'h0, lo:32'h2A}, "post_rst");
      finish("post_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
